nibble_packer: RTL



---
 rtl/nibble_packer.sv | 83 ++++++++
 1 files changed

// File: rtl/nibble_packer.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_packer
//  Purpose  : Packs RATIO IN_W-bit nibbles (LSB nibble first) into one word
//             and presents it with its ones count on a valid/ready output.
//  Revision : 1.0 - initial release
// ============================================================================
module nibble_packer #(
    parameter int IN_W  = 4,
    parameter int RATIO = 2,
    parameter int OUT_W = IN_W * RATIO,
    parameter int CNT_W = $clog2(OUT_W + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_W-1:0]          a,
    input  logic                     load,
    output logic                     in_ready,
    output logic [OUT_W-1:0]         q,
    output logic [CNT_W-1:0]         ones,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(RATIO)-1:0] nib_cnt
);

    localparam int            C_CW    = $clog2(RATIO);
    localparam int            C_ACC_W = OUT_W - IN_W;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(RATIO - 1);

    // Only the lower RATIO-1 nibbles are stored; the last one comes straight from a.
    logic [C_ACC_W-1:0] r_acc;
    logic [OUT_W-1:0]   w_next_q;
    logic [CNT_W-1:0]   w_ones;
    logic               w_last;
    logic               w_in_fire;

    assign w_last    = (nib_cnt == C_LAST);
    assign in_ready  = !(w_last && out_valid && !out_ready);
    assign w_in_fire = load && in_ready;
    assign w_next_q  = {a, r_acc};

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < OUT_W; i++) begin
            w_ones = w_ones + CNT_W'(w_next_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            nib_cnt <= '0;
        end else if (w_in_fire) begin
            if (w_last) begin
                nib_cnt <= '0;
            end else begin
                nib_cnt <= nib_cnt + C_CW'(1);
            end
            for (int i = 0; i < RATIO - 1; i++) begin
                if (nib_cnt == C_CW'(i)) begin
                    r_acc[i*IN_W +: IN_W] <= a;
                end
            end
        end
    end

    // A completing nibble can only fire when the output slot is free or draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q         <= '0;
            ones      <= '0;
            out_valid <= 1'b0;
        end else if (w_in_fire && w_last) begin
            q         <= w_next_q;
            ones      <= w_ones;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
